// File: rtl/vec_operand_streamer_pkg.sv
// Shared types and constants for the vector operand streamer.
package vec_operand_streamer_pkg;

    localparam int unsigned FSIZE     = 32;
    localparam int unsigned VS_ADDR_W = 12;

    typedef struct packed {
        logic [VS_ADDR_W-1:0] src1;
        logic [VS_ADDR_W-1:0] src2;
        logic [VS_ADDR_W:0]   len;
        logic [FSIZE-1:0]     p;
    } vec_stream_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } vs_state_t;

endpackage

// File: rtl/vec_operand_streamer_if.sv
// Command, operand-memory read and beat-stream signals of the streamer.
interface vec_operand_streamer_if
    import vec_operand_streamer_pkg::*;
#(
    parameter int unsigned ADDR_W = VS_ADDR_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_src1;
    logic [ADDR_W-1:0] cmd_src2;
    logic [ADDR_W:0]   cmd_len;
    logic [FSIZE-1:0]  cmd_p;
    logic              hold;
    logic              mem1_rd_en;
    logic [ADDR_W-1:0] mem1_rd_addr;
    logic [FSIZE-1:0]  mem1_rd_data;
    logic              mem2_rd_en;
    logic [ADDR_W-1:0] mem2_rd_addr;
    logic [FSIZE-1:0]  mem2_rd_data;
    logic [FSIZE-1:0]  op1;
    logic [FSIZE-1:0]  op2;
    logic [FSIZE-1:0]  p;
    logic              out_valid;
    logic              out_last;
    logic              busy;
    logic              done;

    // Streamer side
    modport master (
        input  cmd_valid, cmd_src1, cmd_src2, cmd_len, cmd_p, hold,
               mem1_rd_data, mem2_rd_data,
        output cmd_ready, mem1_rd_en, mem1_rd_addr, mem2_rd_en, mem2_rd_addr,
               op1, op2, p, out_valid, out_last, busy, done
    );

    // Command source, memories and beat consumer side
    modport slave (
        output cmd_valid, cmd_src1, cmd_src2, cmd_len, cmd_p, hold,
               mem1_rd_data, mem2_rd_data,
        input  cmd_ready, mem1_rd_en, mem1_rd_addr, mem2_rd_en, mem2_rd_addr,
               op1, op2, p, out_valid, out_last, busy, done
    );

endinterface

// File: rtl/vec_operand_streamer_fifo.sv
// Fixed-latency shift-register delay line (CYCLES stages, reset to zero).
module FifoBuffer #(
    parameter int unsigned DATA_SIZE = 2,
    parameter int unsigned CYCLES    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic [DATA_SIZE-1:0] out_data
);
    logic [DATA_SIZE-1:0] stage_q [CYCLES];

    // Shift the input through CYCLES register stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < CYCLES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= in_data;
            for (int unsigned i = 1; i < CYCLES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_data = stage_q[CYCLES-1];

endmodule

// File: rtl/vec_operand_streamer.sv
// Issues paired operand-memory reads for one vector command and streams
// aligned op1/op2/p beats with valid/last framing, then pulses done.
module vec_operand_streamer
    import vec_operand_streamer_pkg::*;
#(
    parameter int unsigned ADDR_W = VS_ADDR_W,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    vec_operand_streamer_if.master bus
);
    localparam int unsigned     FLT_W   = $clog2(RD_LAT + 3);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);
    localparam logic [FLT_W-1:0] FLT_ONE = FLT_W'(1);

    vs_state_t         state_q, state_d;
    logic [ADDR_W-1:0] src1_q, src2_q;
    logic [ADDR_W:0]   len_q, cnt_q;
    logic [FSIZE-1:0]  p_q, op1_q, op2_q;
    logic              out_valid_q, out_last_q, done_q;
    logic [FLT_W-1:0]  inflight_q, inflight_d;
    logic              accept, issue, issue_last, drained, done_d;
    logic [1:0]        tag_out;

    // Valid/last tags travel alongside the memory read latency
    FifoBuffer #(
        .DATA_SIZE(2),
        .CYCLES   (RD_LAT)
    ) u_tag_delay (
        .clk     (clk),
        .rst     (rst),
        .in_data ({issue, issue_last}),
        .out_data(tag_out)
    );

    // Issue decode, in-flight bookkeeping and next-state logic
    always_comb begin
        state_d    = state_q;
        accept     = (state_q == ST_IDLE) && bus.cmd_valid;
        issue      = (state_q == ST_ISSUE) && !bus.hold;
        issue_last = issue && (cnt_q == len_q - LEN_ONE);
        inflight_d = inflight_q;
        if (issue && !out_valid_q) begin
            inflight_d = inflight_q + FLT_ONE;
        end else if (!issue && out_valid_q) begin
            inflight_d = inflight_q - FLT_ONE;
        end
        // Looking at the post-update count registers done one cycle after the
        // final beat, which also yields the two-cycle zero-length turnaround.
        drained = (inflight_d == '0);
        done_d  = (state_q == ST_DRAIN) && drained;
        case (state_q)
            ST_IDLE:  if (bus.cmd_valid) state_d = (bus.cmd_len == '0) ? ST_DRAIN : ST_ISSUE;
            ST_ISSUE: if (issue_last) state_d = ST_DRAIN;
            ST_DRAIN: if (drained) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, command latch, issue counter and in-flight counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            src1_q     <= '0;
            src2_q     <= '0;
            len_q      <= '0;
            p_q        <= '0;
            cnt_q      <= '0;
            inflight_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            if (accept) begin
                src1_q <= bus.cmd_src1;
                src2_q <= bus.cmd_src2;
                len_q  <= bus.cmd_len;
                p_q    <= bus.cmd_p;
                cnt_q  <= '0;
            end else if (issue) begin
                cnt_q <= cnt_q + LEN_ONE;
            end
        end
    end

    // Output register: capture memory data together with its delayed tags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
        end else begin
            out_valid_q <= tag_out[1];
            out_last_q  <= tag_out[1] & tag_out[0];
            if (tag_out[1]) begin
                op1_q <= bus.mem1_rd_data;
                op2_q <= bus.mem2_rd_data;
            end
        end
    end

    // Drive the interface outputs
    always_comb begin
        bus.cmd_ready    = (state_q == ST_IDLE);
        bus.busy         = (state_q != ST_IDLE);
        bus.mem1_rd_en   = issue;
        bus.mem2_rd_en   = issue;
        bus.mem1_rd_addr = issue ? src1_q + cnt_q[ADDR_W-1:0] : '0;
        bus.mem2_rd_addr = issue ? src2_q + cnt_q[ADDR_W-1:0] : '0;
        bus.op1          = op1_q;
        bus.op2          = op2_q;
        bus.p            = p_q;
        bus.out_valid    = out_valid_q;
        bus.out_last     = out_last_q;
        bus.done         = done_q;
    end

endmodule

// File: tb/tb_vec_operand_streamer.sv
// Randomized scoreboard bench for vec_operand_streamer (RD_LAT=3, ADDR_W=12).
module tb_vec_operand_streamer;
    import vec_operand_streamer_pkg::*;

    localparam int unsigned AW    = VS_ADDR_W;
    localparam int unsigned RL    = 3;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vec_operand_streamer_if #(.ADDR_W(AW)) bus ();

    vec_operand_streamer #(.ADDR_W(AW), .RD_LAT(RL)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Operand memories with fixed read latency RL; unstrobed cycles return noise
    logic [FSIZE-1:0] m1 [DEPTH];
    logic [FSIZE-1:0] m2 [DEPTH];
    logic [FSIZE-1:0] pipe1 [RL];
    logic [FSIZE-1:0] pipe2 [RL];

    always @(posedge clk) begin
        pipe1[0] <= bus.mem1_rd_en ? m1[bus.mem1_rd_addr] : FSIZE'($urandom);
        pipe2[0] <= bus.mem2_rd_en ? m2[bus.mem2_rd_addr] : FSIZE'($urandom);
        for (int i = 1; i < RL; i++) begin
            pipe1[i] <= pipe1[i-1];
            pipe2[i] <= pipe2[i-1];
        end
    end
    assign bus.mem1_rd_data = pipe1[RL-1];
    assign bus.mem2_rd_data = pipe2[RL-1];

    // Reference model expectations
    typedef struct { int cyc; logic [AW-1:0] a1; logic [AW-1:0] a2; } rd_t;
    typedef struct { int cyc; logic [FSIZE-1:0] op1; logic [FSIZE-1:0] op2; logic [FSIZE-1:0] pv; logic last; } beat_t;
    rd_t   rd_q[$];
    beat_t beat_q[$];
    int    done_q[$];
    int    busy_from = 0;
    int    busy_to   = 0;
    logic [FSIZE-1:0] exp_p    = '0;
    logic [FSIZE-1:0] held_op1 = '0;
    logic [FSIZE-1:0] held_op2 = '0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endfunction

    function automatic void overdue(input string nm, input int due);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d: event expected at cycle %0d never appeared", nm, cyc, due);
    endfunction

    // Monitor: compare DUT outputs against the scoreboard every falling edge
    always @(negedge clk) begin : monitor
        bit exp_busy, ev_rd, ev_bt, ev_dn;
        if (!rst) begin
            exp_busy = (cyc >= busy_from) && (cyc < busy_to);
            chk("busy", 64'(bus.busy), 64'(exp_busy));
            chk("cmd_ready", 64'(bus.cmd_ready), 64'(!exp_busy));
            chk("p_stable", 64'(bus.p), 64'(exp_p));

            while (rd_q.size() > 0 && rd_q[0].cyc < cyc) overdue("read_strobe", rd_q.pop_front().cyc);
            ev_rd = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
            if (ev_rd || bus.mem1_rd_en || bus.mem2_rd_en) begin
                chk("mem1_rd_en", 64'(bus.mem1_rd_en), 64'(ev_rd));
                chk("mem2_rd_en", 64'(bus.mem2_rd_en), 64'(ev_rd));
                if (ev_rd) begin
                    chk("mem1_rd_addr", 64'(bus.mem1_rd_addr), 64'(rd_q[0].a1));
                    chk("mem2_rd_addr", 64'(bus.mem2_rd_addr), 64'(rd_q[0].a2));
                    void'(rd_q.pop_front());
                end
            end

            while (beat_q.size() > 0 && beat_q[0].cyc < cyc) overdue("beat", beat_q.pop_front().cyc);
            ev_bt = (beat_q.size() > 0) && (beat_q[0].cyc == cyc);
            if (ev_bt || bus.out_valid) begin
                chk("out_valid", 64'(bus.out_valid), 64'(ev_bt));
                if (ev_bt) begin
                    chk("op1", 64'(bus.op1), 64'(beat_q[0].op1));
                    chk("op2", 64'(bus.op2), 64'(beat_q[0].op2));
                    chk("beat_p", 64'(bus.p), 64'(beat_q[0].pv));
                    chk("out_last", 64'(bus.out_last), 64'(beat_q[0].last));
                    held_op1 = beat_q[0].op1;
                    held_op2 = beat_q[0].op2;
                    void'(beat_q.pop_front());
                end
            end else begin
                chk("out_last_idle", 64'(bus.out_last), 64'(1'b0));
                chk("op1_hold", 64'(bus.op1), 64'(held_op1));
                chk("op2_hold", 64'(bus.op2), 64'(held_op2));
            end

            while (done_q.size() > 0 && done_q[0] < cyc) overdue("done", done_q.pop_front());
            ev_dn = (done_q.size() > 0) && (done_q[0] == cyc);
            if (ev_dn || bus.done) begin
                chk("done", 64'(bus.done), 64'(ev_dn));
                if (ev_dn) void'(done_q.pop_front());
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(1'b0));
        chk({tag, "_out_last"}, 64'(bus.out_last), 64'(1'b0));
        chk({tag, "_done"}, 64'(bus.done), 64'(1'b0));
        chk({tag, "_busy"}, 64'(bus.busy), 64'(1'b0));
        chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'(1'b1));
        chk({tag, "_op1"}, 64'(bus.op1), 64'(0));
        chk({tag, "_op2"}, 64'(bus.op2), 64'(0));
        chk({tag, "_p"}, 64'(bus.p), 64'(0));
        chk({tag, "_rd_en"}, 64'({bus.mem1_rd_en, bus.mem2_rd_en}), 64'(0));
        held_op1 = '0;
        held_op2 = '0;
        exp_p    = '0;
    endtask

    function automatic vec_stream_cmd_t mk(input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                                           input int len, input logic [FSIZE-1:0] pv);
        vec_stream_cmd_t c;
        c.src1 = s1;
        c.src2 = s2;
        c.len  = (AW + 1)'(len);
        c.p    = pv;
        return c;
    endfunction

    // hold_pct < 0 selects the fixed pattern: hold on the 2nd and 3rd issue cycles.
    // rst_at > 0 asserts reset asynchronously in cycle T+rst_at and abandons the command.
    task automatic run_cmd(input vec_stream_cmd_t c, input int hold_pct, input bit poke, input int rst_at);
        int t, issued, done_c, n;
        logic h;
        logic [AW-1:0] a1, a2;
        n = int'(c.len);
        bus.cmd_valid = 1'b1;
        bus.cmd_src1  = c.src1;
        bus.cmd_src2  = c.src2;
        bus.cmd_len   = c.len;
        bus.cmd_p     = c.p;
        t         = cyc;
        busy_from = t + 1;
        busy_to   = 32'h7fff_ffff;
        issued    = 0;
        done_c    = -1;
        if (n == 0) begin
            done_c  = t + 2;
            busy_to = done_c;
            done_q.push_back(done_c);
        end
        next_cycle();
        exp_p = c.p;
        forever begin
            if (rst_at > 0 && cyc == t + rst_at) begin
                #2;
                rst = 1'b1;
                #1;
                check_reset_values("midrst");
                rd_q.delete();
                beat_q.delete();
                done_q.delete();
                busy_from = 0;
                busy_to   = 0;
                bus.cmd_valid = 1'b0;
                bus.hold      = 1'b0;
                next_cycle();
                next_cycle();
                rst = 1'b0;
                next_cycle();
                return;
            end
            if (poke && cyc == t + 1) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_src1  = AW'($urandom);
                bus.cmd_src2  = AW'($urandom);
                bus.cmd_len   = (AW + 1)'($urandom_range(1, 9));
                bus.cmd_p     = FSIZE'($urandom);
            end else begin
                bus.cmd_valid = 1'b0;
            end
            if (hold_pct < 0) h = (cyc == t + 2) || (cyc == t + 3);
            else              h = ($urandom_range(99) < hold_pct);
            bus.hold = h;
            if (issued < n && !h) begin
                a1 = c.src1 + issued[AW-1:0];
                a2 = c.src2 + issued[AW-1:0];
                rd_q.push_back('{cyc: cyc, a1: a1, a2: a2});
                beat_q.push_back('{cyc: cyc + RL + 1, op1: m1[a1], op2: m2[a2], pv: c.p, last: (issued == n - 1)});
                issued++;
                if (issued == n) begin
                    done_c  = cyc + RL + 2;
                    busy_to = done_c;
                    done_q.push_back(done_c);
                end
            end
            if (done_c >= 0 && cyc >= done_c) break;
            next_cycle();
        end
        bus.cmd_valid = 1'b0;
        bus.hold      = 1'b0;
        next_cycle();
    endtask

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_src1  = '0;
        bus.cmd_src2  = '0;
        bus.cmd_len   = '0;
        bus.cmd_p     = '0;
        bus.hold      = 1'b0;
        for (int a = 0; a < int'(DEPTH); a++) begin
            m1[a] = FSIZE'(a);
            m2[a] = FSIZE'(a);
        end
        #2;
        check_reset_values("reset");
        next_cycle();
        next_cycle();
        rst = 1'b0;
        next_cycle();

        run_cmd(mk(12'h010, 12'h200, 4, 32'h0000_FFF1), 0, 1'b0, 0);
        run_cmd(mk(12'hFFE, 12'hFFF, 4, 32'h0000_1001), 0, 1'b0, 0);
        run_cmd(mk(12'h100, 12'h300, 3, 32'h0000_0BAD), -1, 1'b0, 0);
        run_cmd(mk(12'h055, 12'h0AA, 0, 32'h0000_0777), 0, 1'b1, 0);
        run_cmd(mk(12'h123, 12'h456, 5, 32'h0001_0001), 20, 1'b1, 0);

        for (int a = 0; a < int'(DEPTH); a++) begin
            m1[a] = FSIZE'($urandom);
            m2[a] = FSIZE'($urandom);
        end
        run_cmd(mk(12'h700, 12'h800, 8, 32'h00C0_FFEE), 0, 1'b0, 6);
        run_cmd(mk(12'h7FF, 12'h001, 2, 32'h0000_3301), 0, 1'b0, 0);

        for (int k = 0; k < 25; k++) begin
            run_cmd(mk(AW'($urandom), AW'($urandom), int'($urandom_range(0, 24)), FSIZE'($urandom)),
                    30, 1'($urandom_range(1)), 0);
        end
        run_cmd(mk(12'hF00, 12'h0C0, 300, 32'h7FFF_FFFF), 10, 1'b0, 0);

        repeat (RL + 4) next_cycle();
        chk("rd_q_drained", 64'(rd_q.size()), 64'(0));
        chk("beat_q_drained", 64'(beat_q.size()), 64'(0));
        chk("done_q_drained", 64'(done_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
